// File: rtl/sq_err_sweep_ctrl_pkg.sv
// Shared widths, metric sizes and the sweep FSM state type for the squarer error evaluator.
package sq_eval_pkg;

    localparam int unsigned IN_W  = 12;
    localparam int unsigned OUT_W = 14;
    localparam int unsigned CNT_W = IN_W + 1;
    localparam int unsigned SUM_W = OUT_W + IN_W;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/sq_err_sweep_ctrl_if.sv
// Host/datapath-facing signal bundle of the sweep controller.
interface sq_err_sweep_ctrl_if;
    import sq_eval_pkg::*;

    logic             start;
    logic             abort;
    logic [IN_W-1:0]  vec_out;
    logic             vec_valid;
    logic [OUT_W-1:0] approx_in;
    logic [OUT_W-1:0] exact_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [OUT_W-1:0] max_abs_err;
    logic [SUM_W-1:0] sum_abs_err;

    // Controller side
    modport slave (
        input  start, abort, approx_in, exact_in,
        output vec_out, vec_valid, busy, done, err_count, max_abs_err, sum_abs_err
    );

    // Host plus datapath side
    modport master (
        output start, abort, approx_in, exact_in,
        input  vec_out, vec_valid, busy, done, err_count, max_abs_err, sum_abs_err
    );

endinterface

// File: rtl/sq_err_sweep_ctrl_accum.sv
// Two-stage result pipeline: register both results, then fold |approx - exact| into the metrics.
module sq_err_accum
    import sq_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [OUT_W-1:0] approx,
    input  logic [OUT_W-1:0] exact,
    input  logic             flush,
    output logic [CNT_W-1:0] err_count,
    output logic [OUT_W-1:0] max_abs_err,
    output logic [SUM_W-1:0] sum_abs_err
);

    logic             r_s1_valid;
    logic [OUT_W-1:0] r_s1_approx;
    logic [OUT_W-1:0] r_s1_exact;
    logic [CNT_W-1:0] r_err_count;
    logic [OUT_W-1:0] r_max_abs_err;
    logic [SUM_W-1:0] r_sum_abs_err;

    logic [OUT_W:0]   w_diff;
    logic [OUT_W:0]   w_abs_full;
    logic [OUT_W-1:0] w_abs;

    // Difference at OUT_W+1 bits (two's complement), magnitude truncated back to OUT_W
    always_comb begin
        w_diff     = {1'b0, r_s1_approx} - {1'b0, r_s1_exact};
        w_abs_full = w_diff[OUT_W] ? (~w_diff + 1'b1) : w_diff;
        w_abs      = w_abs_full[OUT_W-1:0];
    end

    // Stage 1: capture both results; a flush drops whatever is being captured
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_s1_valid  <= 1'b0;
            r_s1_approx <= '0;
            r_s1_exact  <= '0;
        end else begin
            r_s1_valid <= valid && !flush;
            if (valid) begin
                r_s1_approx <= approx;
                r_s1_exact  <= exact;
            end
        end
    end

    // Stage 2: accumulate; on flush the pending stage-1 entry is discarded, metrics hold
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_err_count   <= '0;
            r_max_abs_err <= '0;
            r_sum_abs_err <= '0;
        end else if (r_s1_valid && !flush) begin
            r_err_count   <= r_err_count + CNT_W'(w_abs != '0);
            r_max_abs_err <= (w_abs > r_max_abs_err) ? w_abs : r_max_abs_err;
            r_sum_abs_err <= r_sum_abs_err + SUM_W'(w_abs);
        end
    end

    assign err_count   = r_err_count;
    assign max_abs_err = r_max_abs_err;
    assign sum_abs_err = r_sum_abs_err;

endmodule

// File: rtl/sq_err_sweep_ctrl.sv
// Sweep sequencer: walks the full operand space and feeds the error accumulator.
module sq_err_sweep_ctrl
    import sq_eval_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    sq_err_sweep_ctrl_if.slave  bus
);

    state_e          r_state;
    logic [IN_W-1:0] r_vec;
    logic            r_vec_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_drain_cnt;

    logic            w_clear;
    logic            w_flush;

    assign w_clear = bus.start && (r_state == StIdle || r_state == StDone);
    assign w_flush = bus.abort && (r_state == StSweep || r_state == StDrain);

    // Sweep FSM with registered vector and status outputs; abort beats start while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_state     <= StSweep;
                        r_vec       <= '0;
                        r_vec_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                StSweep: begin
                    if (bus.abort) begin
                        r_state     <= StIdle;
                        r_vec_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_vec == '1) begin
                        r_state     <= StDrain;
                        r_vec_valid <= 1'b0;
                        r_drain_cnt <= 1'b0;
                    end else begin
                        r_vec <= r_vec + 1'b1;
                    end
                end
                StDrain: begin
                    if (bus.abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.vec_out   = r_vec;
    assign bus.vec_valid = r_vec_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    sq_err_accum u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_clear),
        .valid       (r_vec_valid),
        .approx      (bus.approx_in),
        .exact       (bus.exact_in),
        .flush       (w_flush),
        .err_count   (bus.err_count),
        .max_abs_err (bus.max_abs_err),
        .sum_abs_err (bus.sum_abs_err)
    );

endmodule
